// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: shift operations,
// shift directions and burst-engine FSM states.
package shift_reg_pkg;

  localparam logic [1:0] OP_LOGIC  = 2'b00;
  localparam logic [1:0] OP_ROTATE = 2'b01;
  localparam logic [1:0] OP_ARITH  = 2'b10;
  localparam logic [1:0] OP_HOLD   = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/univ_shift_reg_shift_step.sv
// Combinational single-step shifter: computes the register value after one
// shift of the requested operation and direction.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [1:0]       op_i,
  input  logic             dir_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] next_o
);

  // Select the shifted value; the reserved op code leaves the value untouched.
  always_comb begin
    next_o = value_i;
    case (op_i)
      OP_LOGIC: begin
        if (dir_i == DIR_RIGHT) next_o = {d_i, value_i[WIDTH-1:1]};
        else                    next_o = {value_i[WIDTH-2:0], d_i};
      end
      OP_ROTATE: begin
        if (dir_i == DIR_RIGHT) next_o = {value_i[0], value_i[WIDTH-1:1]};
        else                    next_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
      end
      OP_ARITH: begin
        if (dir_i == DIR_RIGHT) next_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
        else                    next_o = {value_i[WIDTH-2:0], 1'b0};
      end
      default: next_o = value_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, free-running shift and a counted
// burst-shift engine.
//
// Burst handshake: the controller pulses start with a non-zero count while
// busy is low; busy stays high until the final shift edge, after which done
// is high for exactly one cycle. start is ignored while busy, a parallel
// load aborts a burst silently (no done), and en acts as a per-cycle
// advance qualifier during the burst. A zero count completes immediately
// with a done pulse and never raises busy.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       op,
  input  logic             d,
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic [1:0]       step_op;
  logic             step_dir;
  logic [WIDTH-1:0] step_out;

  // A running burst uses the op/dir captured at start; otherwise the live ones.
  assign step_op  = (state_q == RUN) ? op_q  : op;
  assign step_dir = (state_q == RUN) ? dir_q : dir;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .value_i (out_q),
    .op_i    (step_op),
    .dir_i   (step_dir),
    .d_i     (d),
    .next_o  (step_out)
  );

  // Next-state logic: load beats burst control, which beats free-running shift.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rem_d   = rem_q;
    op_d    = op_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (load) begin
      out_d   = pdata;
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              op_d    = op;
              dir_d   = dir;
              rem_d   = count;
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end else if (en) begin
            out_d = step_out;
          end
        end
        RUN: begin
          if (en) begin
            out_d = step_out;
            if (rem_q == CNT_W'(1)) begin
              rem_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              rem_d = rem_q - CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_LOGIC;
      dir_q   <= DIR_LEFT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sout = (dir == DIR_RIGHT) ? out_q[0] : out_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=16): table of per-edge vectors with
// hand-derived expectations fed through an expected-value queue, plus a
// hand-written asynchronous-reset-mid-burst sequence.
module tb_univ_shift_reg;

  localparam int W  = 16;
  localparam int CW = 5;
  localparam int NV = 35;

  localparam logic [1:0] LG = 2'b00;
  localparam logic [1:0] RT = 2'b01;
  localparam logic [1:0] AR = 2'b10;
  localparam logic [1:0] HD = 2'b11;

  logic          clk;
  logic          reset;
  logic          en;
  logic          dir;
  logic [1:0]    op;
  logic          d;
  logic          load;
  logic [W-1:0]  pdata;
  logic          start;
  logic [CW-1:0] count;
  logic [W-1:0]  out;
  logic          sout;
  logic          busy;
  logic          done;

  typedef struct {
    logic          ld;
    logic [W-1:0]  pd;
    logic          en;
    logic          dr;
    logic [1:0]    op;
    logic          d;
    logic          st;
    logic [CW-1:0] cnt;
    logic [W-1:0]  e_out;
    logic          e_busy;
    logic          e_done;
    logic          e_sout;
  } vec_t;

  vec_t vecs[NV];
  logic [W+2:0] exp_q[$];

  int total_cnt = 0;
  int pass_cnt  = 0;

  univ_shift_reg #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .dir   (dir),
    .op    (op),
    .d     (d),
    .load  (load),
    .pdata (pdata),
    .start (start),
    .count (count),
    .out   (out),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic ld, input logic [W-1:0] pd, input logic e,
                              input logic dr, input logic [1:0] o, input logic dd,
                              input logic st, input logic [CW-1:0] c,
                              input logic [W-1:0] eo, input logic eb, input logic ed,
                              input logic es);
    vec_t v;
    v.ld = ld; v.pd = pd; v.en = e; v.dr = dr; v.op = o; v.d = dd;
    v.st = st; v.cnt = c; v.e_out = eo; v.e_busy = eb; v.e_done = ed; v.e_sout = es;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  // Driver: present one vector, queue its expectation, compare after the edge.
  task automatic apply(input int idx);
    logic [W+2:0] e;
    load  = vecs[idx].ld;
    pdata = vecs[idx].pd;
    en    = vecs[idx].en;
    dir   = vecs[idx].dr;
    op    = vecs[idx].op;
    d     = vecs[idx].d;
    start = vecs[idx].st;
    count = vecs[idx].cnt;
    exp_q.push_back({vecs[idx].e_out, vecs[idx].e_busy, vecs[idx].e_done, vecs[idx].e_sout});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("out",  idx, 32'(out),  32'(e[W+2:3]));
    check("busy", idx, 32'(busy), 32'(e[2]));
    check("done", idx, 32'(done), 32'(e[1]));
    check("sout", idx, 32'(sout), 32'(e[0]));
  endtask

  task automatic drive(input logic ld, input logic e, input logic dr, input logic [1:0] o,
                       input logic dd, input logic st, input logic [CW-1:0] c);
    load = ld; en = e; dir = dr; op = o; d = dd; start = st; count = c;
  endtask

  initial begin
    int n;
    // ld  pdata    en dr op  d  st cnt    out      busy done sout
    vecs[0]  = mk(1, 16'hA5C3, 0, 0, LG, 0, 0, 5'd0, 16'hA5C3, 0, 0, 1);
    vecs[1]  = mk(1, 16'h0000, 0, 0, LG, 0, 0, 5'd0, 16'h0000, 0, 0, 0);
    vecs[2]  = mk(0, 16'h0000, 1, 0, LG, 1, 0, 5'd0, 16'h0001, 0, 0, 0);
    vecs[3]  = mk(0, 16'h0000, 1, 0, LG, 0, 0, 5'd0, 16'h0002, 0, 0, 0);
    vecs[4]  = mk(0, 16'h0000, 1, 0, LG, 1, 0, 5'd0, 16'h0005, 0, 0, 0);
    vecs[5]  = mk(0, 16'h0000, 1, 0, LG, 0, 0, 5'd0, 16'h000A, 0, 0, 0);
    vecs[6]  = mk(0, 16'h0000, 0, 0, LG, 1, 0, 5'd0, 16'h000A, 0, 0, 0);
    vecs[7]  = mk(0, 16'h0000, 1, 0, HD, 1, 0, 5'd0, 16'h000A, 0, 0, 0);
    vecs[8]  = mk(0, 16'h0000, 1, 1, RT, 0, 0, 5'd0, 16'h0005, 0, 0, 1);
    vecs[9]  = mk(0, 16'h0000, 1, 0, AR, 0, 0, 5'd0, 16'h000A, 0, 0, 0);
    // burst rotate right by 4
    vecs[10] = mk(1, 16'h1234, 0, 0, LG, 0, 0, 5'd0, 16'h1234, 0, 0, 0);
    vecs[11] = mk(0, 16'h0000, 1, 1, RT, 0, 1, 5'd4, 16'h1234, 1, 0, 0);
    vecs[12] = mk(0, 16'h0000, 1, 1, RT, 0, 0, 5'd0, 16'h091A, 1, 0, 0);
    vecs[13] = mk(0, 16'h0000, 1, 1, RT, 0, 0, 5'd0, 16'h048D, 1, 0, 1);
    vecs[14] = mk(0, 16'h0000, 1, 1, RT, 0, 0, 5'd0, 16'h8246, 1, 0, 0);
    vecs[15] = mk(0, 16'h0000, 1, 1, RT, 0, 0, 5'd0, 16'h4123, 0, 1, 1);
    vecs[16] = mk(0, 16'h0000, 0, 1, RT, 0, 0, 5'd0, 16'h4123, 0, 0, 1);
    // burst arith right by 3 with a 2-cycle stall and mid-burst op/dir changes
    vecs[17] = mk(1, 16'h8000, 0, 0, LG, 0, 0, 5'd0, 16'h8000, 0, 0, 1);
    vecs[18] = mk(0, 16'h0000, 1, 1, AR, 0, 1, 5'd3, 16'h8000, 1, 0, 0);
    vecs[19] = mk(0, 16'h0000, 1, 0, LG, 1, 0, 5'd0, 16'hC000, 1, 0, 1);
    vecs[20] = mk(0, 16'h0000, 0, 0, RT, 0, 0, 5'd0, 16'hC000, 1, 0, 1);
    vecs[21] = mk(0, 16'h0000, 0, 0, RT, 0, 0, 5'd0, 16'hC000, 1, 0, 1);
    vecs[22] = mk(0, 16'h0000, 1, 1, LG, 1, 0, 5'd0, 16'hE000, 1, 0, 0);
    vecs[23] = mk(0, 16'h0000, 1, 1, LG, 1, 0, 5'd0, 16'hF000, 0, 1, 0);
    vecs[24] = mk(0, 16'h0000, 0, 1, LG, 0, 0, 5'd0, 16'hF000, 0, 0, 0);
    // zero-count start, then start ignored while running
    vecs[25] = mk(0, 16'h0000, 1, 0, LG, 1, 1, 5'd0, 16'hF000, 0, 1, 1);
    vecs[26] = mk(0, 16'h0000, 0, 0, LG, 0, 0, 5'd0, 16'hF000, 0, 0, 1);
    vecs[27] = mk(0, 16'h0000, 1, 0, LG, 0, 1, 5'd2, 16'hF000, 1, 0, 1);
    vecs[28] = mk(0, 16'h0000, 1, 0, LG, 1, 1, 5'd5, 16'hE001, 1, 0, 1);
    vecs[29] = mk(0, 16'h0000, 1, 0, LG, 0, 1, 5'd5, 16'hC002, 0, 1, 1);
    vecs[30] = mk(0, 16'h0000, 0, 0, LG, 0, 0, 5'd0, 16'hC002, 0, 0, 1);
    // load aborts a running burst without a done pulse
    vecs[31] = mk(0, 16'h0000, 1, 0, RT, 0, 1, 5'd3, 16'hC002, 1, 0, 1);
    vecs[32] = mk(0, 16'h0000, 1, 0, RT, 0, 0, 5'd0, 16'h8005, 1, 0, 1);
    vecs[33] = mk(1, 16'h5A5A, 1, 0, RT, 0, 0, 5'd0, 16'h5A5A, 0, 0, 0);
    vecs[34] = mk(0, 16'h0000, 0, 0, RT, 0, 0, 5'd0, 16'h5A5A, 0, 0, 0);

    reset = 1'b1;
    pdata = '0;
    drive(0, 0, 0, LG, 0, 0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out",  0, 32'(out),  32'h0);
    check("rst_busy", 0, 32'(busy), 32'h0);
    check("rst_done", 0, 32'(done), 32'h0);
    check("rst_sout", 0, 32'(sout), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) apply(i);

    // Asynchronous reset in the middle of an 8-shift burst from 16'h5A5A.
    drive(0, 1, 0, LG, 0, 1, 5'd8);
    @(posedge clk);
    #1;
    check("ar_busy0", 0, 32'(busy), 32'h1);
    drive(0, 1, 0, LG, 0, 0, 5'd0);
    @(posedge clk);
    #1;
    check("ar_out1", 0, 32'(out), 32'hB4B4);
    #2;
    reset = 1'b1;
    #1;
    check("ar_out",  0, 32'(out),  32'h0);
    check("ar_busy", 0, 32'(busy), 32'h0);
    check("ar_done", 0, 32'(done), 32'h0);
    @(negedge clk);
    // Release reset together with a fresh 2-shift burst, shifting in ones.
    reset = 1'b0;
    drive(0, 1, 0, LG, 1, 1, 5'd2);
    @(posedge clk);
    #1;
    check("fr_busy", 0, 32'(busy), 32'h1);
    check("fr_done", 0, 32'(done), 32'h0);
    check("fr_out",  0, 32'(out),  32'h0);
    drive(0, 1, 0, LG, 1, 0, 5'd0);
    n = 0;
    while (n < 8) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    check("fr_latency", 0, 32'(n),    32'd2);
    check("fr_out2",    0, 32'(out),  32'h0003);
    check("fr_busy2",   0, 32'(busy), 32'h0);
    drive(0, 0, 0, LG, 0, 0, 5'd0);
    @(posedge clk);
    #1;
    check("fr_done_clr", 0, 32'(done), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
